// File: rtl/axi4mm_write_master.sv
// axi4mm_write_master
//   Issues one complete AXI4 write transaction (AW, W burst, B) per accepted
//   command. FIXED, INCR and WRAP bursts are supported. Illegal commands are
//   rejected with a cmd_err pulse and cause no bus activity. One transaction
//   may be outstanding at a time.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_addr,
//   cmd_len, cmd_burst            burst command from the channel controller
//   s_data, s_strb, s_valid/ready beat stream, passed straight through to W
//   aw*                           AXI write address channel
//   w*                            AXI write data channel
//   bid, bresp, bvalid, bready    AXI write response channel
//   done                          one-cycle pulse after the B handshake
//   status                        bresp of last transaction, SLVERR on ID mismatch
//   cmd_err                       one-cycle pulse after a rejected command
module axi4mm_write_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int ID_WIDTH   = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [1:0]              cmd_burst,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_strb,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    wvalid,
  input  logic                    wready,
  output logic                    wlast,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    done,
  output logic [1:0]              status,
  output logic                    cmd_err
);

  localparam int         BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE  = 3'($clog2(BYTES));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic [1:0]            r_awburst;
  logic [7:0]            r_beat_cnt;
  logic [ID_WIDTH-1:0]   r_txn_cnt;
  logic [1:0]            r_status;
  logic                  r_done;
  logic                  r_cmd_err;
  logic                  r_cmd_ready;

  logic        w_cmd_fire;
  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_b_fire;
  logic        w_last_beat;
  logic        w_wvalid;
  logic        w_misaligned;
  logic        w_wrap_bad;
  logic        w_fixed_bad;
  logic        w_incr_bad;
  logic        w_illegal;
  logic [31:0] w_incr_end;

  // r_cmd_ready is only ever high in IDLE, so it doubles as the IDLE qualifier.
  assign w_cmd_fire  = cmd_valid && r_cmd_ready;
  assign w_aw_fire   = (r_state == S_ADDR) && awready;
  assign w_w_fire    = w_wvalid && wready;
  assign w_b_fire    = (r_state == S_RESP) && bvalid;
  assign w_last_beat = (r_beat_cnt == r_awlen);

  // Command legality checks.
  assign w_incr_end   = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) * 32'(BYTES));
  assign w_misaligned = (cmd_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign w_wrap_bad   = (cmd_burst == 2'd2) &&
                        !((cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                          (cmd_len == 8'd7) || (cmd_len == 8'd15));
  assign w_fixed_bad  = (cmd_burst == 2'd0) && (cmd_len > 8'd15);
  assign w_incr_bad   = (cmd_burst == 2'd1) && (w_incr_end > 32'd4096);
  assign w_illegal    = (cmd_burst == 2'd3) || w_misaligned || w_wrap_bad ||
                        w_fixed_bad || w_incr_bad;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_fire && !w_illegal)  w_state_next = S_ADDR;
      S_ADDR: if (w_aw_fire)                 w_state_next = S_DATA;
      S_DATA: if (w_w_fire && w_last_beat)   w_state_next = S_RESP;
      S_RESP: if (bvalid)                    w_state_next = S_IDLE;
      default:                               w_state_next = S_IDLE;
    endcase
  end

  // Output logic: W is a pure passthrough gated by the DATA state.
  always_comb begin
    w_wvalid = (r_state == S_DATA) && s_valid;
    wvalid   = w_wvalid;
    s_ready  = (r_state == S_DATA) && wready;
    wlast    = w_wvalid && w_last_beat;
    awvalid  = (r_state == S_ADDR);
    bready   = (r_state == S_RESP);
  end

  // Datapath registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_awburst   <= '0;
      r_beat_cnt  <= '0;
      r_txn_cnt   <= '0;
      r_status    <= '0;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_done    <= w_b_fire;
      r_cmd_err <= w_cmd_fire && w_illegal;
      // Held low during the done cycle so the next command lands after done.
      r_cmd_ready <= (w_state_next == S_IDLE) && !w_b_fire;
      if (w_cmd_fire && !w_illegal) begin
        r_awaddr  <= cmd_addr;
        r_awlen   <= cmd_len;
        r_awburst <= cmd_burst;
      end
      if (w_aw_fire)     r_beat_cnt <= '0;
      else if (w_w_fire) r_beat_cnt <= r_beat_cnt + 8'd1;
      if (w_b_fire) begin
        r_status  <= (bid == r_txn_cnt) ? bresp : 2'b10;
        r_txn_cnt <= r_txn_cnt + 1'b1;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign awid      = r_txn_cnt;
  assign awaddr    = r_awaddr;
  assign awlen     = r_awlen;
  assign awsize    = SIZE;
  assign awburst   = r_awburst;
  assign wdata     = s_data;
  assign wstrb     = s_strb;
  assign done      = r_done;
  assign status    = r_status;
  assign cmd_err   = r_cmd_err;

endmodule

// File: doc/axi4mm_write_master.md
# axi4mm_write_master

Parametrised AXI4 memory-mapped write master: accepts a burst command plus a beat stream from the DMA datapath and issues one complete AXI4 write transaction (AW, W burst, B). It supports FIXED, INCR and WRAP bursts with per-beat byte strobes, illegal-command rejection and response/ID checking. It sits between the DMA channel controller and the AXI interconnect. It allows one outstanding transaction at a time.

## Interface
- DATA_WIDTH, 32: W data bits; power of two, 8..1024.
- ADDR_WIDTH, 20: address bits; at least 12.
- ID_WIDTH, 2: AWID/BID bits.
- aclk  in  1  single clock, rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_len  in  8  beats minus 1 (AXI AWLEN encoding).
- cmd_burst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- s_data / s_strb  in  DATA_WIDTH / DATA_WIDTH/8  beat payload and byte enables.
- s_valid / s_ready  in / out  1 / 1  beat handshake.
- awvalid / awready  out / in  1 / 1  AW handshake.
- awid / awaddr / awlen  out  ID_WIDTH / ADDR_WIDTH / 8  AW fields.
- awsize / awburst  out  3 / 2  AW fields.
- wvalid / wready / wlast  out / in / out  1 each  W handshake and last-beat flag.
- wdata / wstrb  out  DATA_WIDTH / DATA_WIDTH/8  W payload.
- bid / bresp / bvalid / bready  in / in / in / out  ID_WIDTH / 2 / 1 / 1  B channel.
- done  out  1  one-cycle pulse when a transaction completes.
- status  out  2  latched bresp of the last transaction; forced to 2'b10 (SLVERR) on ID mismatch.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

## Operation
- State machine states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - cmd_ready=1.
  - Command fires on cmd_valid&&cmd_ready.
  - A fired command is rejected if any of these hold:
    - cmd_burst==3;
    - cmd_addr is not aligned to DATA_WIDTH/8;
    - WRAP with cmd_len not in {1,3,7,15};
    - FIXED with cmd_len>15;
    - INCR where cmd_addr[11:0] + (cmd_len+1)*DATA_WIDTH/8 > 4096 (4 KB crossing).
  - On rejection: cmd_err pulses next cycle, state stays IDLE, no AXI activity.
  - A legal command registers the AW fields and moves to ADDR.
- **ADDR**
  - awvalid=1, holding all AW fields stable until awready.
  - awsize = log2(DATA_WIDTH/8).
  - awid = the transaction counter, which starts at 0, increments after each done, and wraps modulo 2^ID_WIDTH.
  - On awvalid&&awready, move to DATA; beat counter = 0.
- **DATA**
  - wdata=s_data, wstrb=s_strb.
  - wvalid=s_valid, s_ready=wready (both gated by state==DATA).
  - wlast = (beat counter == awlen).
  - Each wvalid&&wready increments the beat counter.
  - The beat with wlast moves to RESP.
- **RESP**
  - bready=1.
  - On bvalid: status = (bid==awid) ? bresp : 2'b10; done pulses for one cycle; state returns to IDLE.
- W data is never issued before the AW handshake.
- Reset mid-operation abandons the transaction; no done and no cmd_err are issued.

## Timing
- Reset values:
  - awvalid, wvalid, wlast, bready, done, cmd_err, s_ready: 0.
  - cmd_ready, awid, awaddr, awlen, awburst, status: 0.
  - awsize = log2(DATA_WIDTH/8).
  - State = IDLE; transaction counter = 0.
- Command fire at cycle T: awvalid is high at T+1 (registered).
- Minimum transaction length, with zero-wait slave and always-valid source:
  - AW handshake at T+1;
  - beats at T+2 .. T+2+awlen;
  - bvalid earliest one cycle later;
  - done the cycle after the B handshake.
- cmd_ready=0 from the cycle after fire until the state returns to IDLE. A new command is accepted no earlier than the cycle after done.
- W beats are combinational passthrough; no internal buffering. Back-pressure from wready propagates to s_ready in the same cycle.
- wlast is asserted only while wvalid is high on the final beat. wlast is never asserted for a beat index other than awlen.
- bvalid arriving while in DATA is ignored: bready=0 until RESP.
- awlen=0: a single beat, with wlast high on it.

## Test plan
- INCR, addr 0x100, len 3, zero-wait slave, DATA_WIDTH 32 -> awaddr 0x100, awlen 3, awsize 2, awburst 1; four beats with wlast on the fourth only; bresp 0 gives done pulse and status 0.
- Random wready/s_valid stalls on a len 7 WRAP at 0x20 -> exactly 8 beats, data order preserved, no beat duplicated or dropped, wlast on beat 7.
- Illegal commands (burst 3; addr 0x102; WRAP len 2; INCR addr 0xFF0 len 7 with 4-byte beats) -> cmd_err pulse each time; awvalid stays 0; cmd_ready stays 1.
- awready held low 5 cycles -> AW fields stable throughout; wvalid stays 0 until after the AW handshake.
- bresp 2'b10, then a transaction whose bid != awid with bresp 0 -> status 2'b10 both times; awid increments 0,1,2,3,0 across five transactions.
- aresetn asserted mid-DATA (beat 2 of 4) -> all outputs return to reset values asynchronously; a fresh command after release completes normally with awid 0.
